// File: rtl/uart_state_sync.sv
// Frame receiver for the tagged 16-bit UART word stream: checks per-frame XOR
// checksums and commits decoded game state to the drawing stages on vblank.
module uart_state_sync #(
  parameter int unsigned GAP_TIMEOUT  = 1024,
  parameter int unsigned LINK_TIMEOUT = 4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  input  logic        vblnk,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        state_updated,
  output logic        link_ok,
  output logic [7:0]  frame_err_cnt
);
  localparam int unsigned GAP_W  = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;
  localparam int unsigned LINK_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(LINK_TIMEOUT);

  localparam logic [3:0] TAG_START = 4'hE;
  localparam logic [3:0] TAG_END   = 4'hF;

  typedef enum logic {HUNT, COLLECT} state_t;

  typedef struct packed {
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] bx;
    logic [11:0] by;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        fp;
    logic        eg;
  } game_t;

  state_t            state;
  game_t             collect, pending, committed;
  logic              pend_valid;
  logic [11:0]       acc;
  logic [GAP_W-1:0]  gap_cnt;
  logic [LINK_W-1:0] link_cnt;
  logic              seen;
  logic              vblnk_q, vblnk_qq;

  logic [3:0]  tag;
  logic [11:0] payload;
  logic        is_data;
  logic        edge_det;
  logic        frame_err;

  assign tag      = word_in[15:12];
  assign payload  = word_in[11:0];
  assign is_data  = (tag >= 4'h1) && (tag <= 4'h5);
  assign edge_det = vblnk_q & ~vblnk_qq;

  always_comb begin
    frame_err = 1'b0;
    if (state == COLLECT) begin
      if (word_valid) begin
        if (tag == TAG_END) frame_err = (payload != acc);
        else if (!is_data)  frame_err = 1'b1;
      end else begin
        frame_err = (gap_cnt == GAP_LAST);
      end
    end
  end

  // Commit runs before the parser in this block so a FRAME_END landing on the
  // commit cycle re-arms pend_valid for the next edge (later NBA wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      collect       <= '0;
      pending       <= '0;
      committed     <= '0;
      pend_valid    <= 1'b0;
      acc           <= '0;
      gap_cnt       <= '0;
      link_cnt      <= '0;
      seen          <= 1'b0;
      vblnk_q       <= 1'b0;
      vblnk_qq      <= 1'b0;
      state_updated <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      vblnk_q       <= vblnk;
      vblnk_qq      <= vblnk_q;
      state_updated <= 1'b0;

      if (link_cnt != LINK_MAX) link_cnt <= link_cnt + LINK_W'(1);
      if (edge_det && pend_valid) begin
        committed     <= pending;
        pend_valid    <= 1'b0;
        state_updated <= 1'b1;
        link_cnt      <= '0;
        seen          <= 1'b1;
      end

      if (frame_err && (frame_err_cnt != '1)) frame_err_cnt <= frame_err_cnt + 8'd1;

      case (state)
        HUNT: begin
          if (word_valid && (tag == TAG_START)) begin
            collect <= pending;
            acc     <= '0;
            gap_cnt <= '0;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (word_valid) begin
            gap_cnt <= '0;
            case (tag)
              4'h1: begin collect.px <= payload; acc <= acc ^ payload; end
              4'h2: begin collect.py <= payload; acc <= acc ^ payload; end
              4'h3: begin collect.bx <= payload; acc <= acc ^ payload; end
              4'h4: begin collect.by <= payload; acc <= acc ^ payload; end
              4'h5: begin
                collect.s1 <= payload[7:4];
                collect.s2 <= payload[3:0];
                collect.fp <= payload[8];
                collect.eg <= payload[9];
                acc        <= acc ^ payload;
              end
              TAG_END: begin
                state <= HUNT;
                if (payload == acc) begin
                  pending    <= collect;
                  pend_valid <= 1'b1;
                end
              end
              TAG_START: begin
                collect <= pending;
                acc     <= '0;
              end
              default: state <= HUNT;
            endcase
          end else if (gap_cnt == GAP_LAST) begin
            state <= HUNT;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign pl1_posx   = committed.px;
  assign pl1_posy   = committed.py;
  assign ball_posx  = committed.bx;
  assign ball_posy  = committed.by;
  assign pl1_score  = committed.s1;
  assign pl2_score  = committed.s2;
  assign flag_point = committed.fp;
  assign end_game   = committed.eg;
  assign link_ok    = seen && (link_cnt < LINK_MAX);
endmodule

// File: doc/uart_state_sync.md
Name: uart_state_sync

Overview:
Frame-level receiver between the 16-bit UART word stream (uart data_out / conv8to16valid) and the drawing stages (player, ball, score, menu).
- Parses tagged words into frames and checks a per-frame XOR checksum.
- Double-buffers the decoded game state and commits it to its outputs only on the rising edge of vertical blanking, so sprites never tear mid-frame.
- Reports link health and frame errors.

Parameters:
GAP_TIMEOUT, 1024, maximum clk cycles allowed between words inside one frame before the frame is dropped.
LINK_TIMEOUT, 4000000, clk cycles without a committed frame before link_ok deasserts (~61 ms at 65 MHz).

Ports:
clk  in  1  pixel clock, 65 MHz.
rst  in  1  asynchronous, active-low reset.
word_in  in  16  received word: [15:12] tag, [11:0] payload.
word_valid  in  1  one-cycle strobe; word_in is valid this cycle.
vblnk  in  1  vertical blanking from vga_timing.
pl1_posx, pl1_posy  out  12 each  committed player-1 position.
ball_posx, ball_posy  out  12 each  committed ball position.
pl1_score, pl2_score  out  4 each  committed scores.
flag_point  out  1  committed last-point flag.
end_game  out  1  committed end-of-game flag.
state_updated  out  1  one-cycle pulse on each commit.
link_ok  out  1  a frame was committed within the last LINK_TIMEOUT cycles.
frame_err_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Reset (async assert, sync release): all outputs 0; pending and collect buffers 0; pend_valid 0; FSM in HUNT; gap counter 0; link counter 0.
- Tags:
  - 0xE FRAME_START.
  - 0x1 pl1_posx, 0x2 pl1_posy, 0x3 ball_posx, 0x4 ball_posy.
  - 0x5 status: payload[7:4] pl1_score, [3:0] pl2_score, [8] flag_point, [9] end_game, [11:10] ignored.
  - 0xF FRAME_END: payload is the checksum.
  - All other tags are illegal.
- HUNT:
  - Only FRAME_START is acted on; all other words are ignored without counting an error.
  - On FRAME_START: collect buffer <= pending buffer (fields absent from a frame keep their last accepted value); checksum accumulator <= 0; gap counter <= 0; go to COLLECT.
- COLLECT:
  - Data tag 0x1..0x5: write the field; accumulator ^= payload; gap counter <= 0.
  - FRAME_END with payload == accumulator: pending buffer <= collect buffer; pend_valid <= 1; go to HUNT. If a frame is already pending, the newest frame wins.
  - FRAME_END with payload != accumulator: discard; error; go to HUNT.
  - Illegal tag: discard; error; go to HUNT.
  - FRAME_START: error on the aborted frame, then restart collection exactly as from HUNT.
  - Gap counter reaches GAP_TIMEOUT-1 with no word: discard; error; go to HUNT.
- Error: frame_err_cnt increments by 1 and saturates at 255.
- Commit:
  - vblnk is registered once internally; its rising edge is detected one cycle after vblnk rises.
  - On a detected edge with pend_valid=1: outputs <= pending buffer; pend_valid <= 0; state_updated=1 for exactly one cycle; link counter <= 0.
  - Outputs change 1 cycle after edge detection, 2 cycles after vblnk rises.
- Same cycle as a detected edge, a valid FRAME_END completes:
  - The commit uses the pending contents from before this cycle.
  - The new frame becomes pending with pend_valid=1 and commits at the next edge.
  - If nothing was pending, no commit occurs this edge.
- Link status:
  - The link counter increments every cycle and saturates at LINK_TIMEOUT.
  - link_ok = (counter < LINK_TIMEOUT) AND at least one commit has occurred since reset.
- Reset asserted mid-frame: immediate return to the reset state. Outputs go to 0 asynchronously.

Test Plan:
1. Send START, {1,0x064}, {3,0x200}, END(0x064^0x200=0x264), then pulse vblnk. Required: pl1_posx=100 and ball_posx=512 2 cycles after vblnk rises; state_updated pulses once; link_ok=1.
2. Send the same frame with END payload 0x265. Required: frame_err_cnt=1; outputs unchanged at the next vblnk; no state_updated.
3. Send START, {1,0x010}, then no word for 1024 cycles, then END. Required: error count +1 at the timeout; the late END is ignored in HUNT; no commit.
4. Send two valid frames (pl1_posy 0x0AA then 0x0BB) before one vblnk edge. Required: commit shows 0x0BB; a single state_updated pulse.
5. Complete a valid frame on exactly the cycle the vblnk edge is detected, with a prior frame pending. Required: the prior values commit now; the new values commit at the next edge.
6. Send status payload 0x3A5, then 300 invalid frames. Required: pl1_score=10, pl2_score=5, flag_point=1, end_game=1; frame_err_cnt saturates at 255; with LINK_TIMEOUT reduced to 100 for the bench, link_ok drops after 100 idle cycles.
